// File: rtl/robo_step_scheduler.sv
// Robot step sequencer: frame-paced autonomous steps or gamepad-driven moves.
// Optional STEP_COUNTER_EN adds ContadorPassos, a saturating count of effective steps.
module robo_step_scheduler #(
  parameter int GRID_COLS       = 20,
  parameter int GRID_ROWS       = 15,
  parameter int FRAMES_PER_STEP = 30,
  parameter int SETTLE_CYCLES   = 4,
  parameter int INIT_COL        = 0,
  parameter int INIT_ROW        = 0
) (
  input  logic        Clock50,
  input  logic        Reset,
  input  logic        v_sync,
  input  logic [11:0] Entradas,
  input  logic        avancar,
  input  logic        girar,
  input  logic        remover,
  output logic        AtivaRobo,
  output logic [4:0]  PosColuna,
  output logic [3:0]  PosLinha,
  output logic [1:0]  OrientacaoRobo,
  output logic        ModoManual,
  output logic        RemoverStrobe,
`ifdef STEP_COUNTER_EN
  output logic [15:0] ContadorPassos,
`endif
  output logic        Busy
);

  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_SETTLE, S_APPLY} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ADV, OP_CW, OP_CCW, OP_REM} op_t;

  state_t          r_state, w_next;
  op_t             r_op, r_buf_op, w_dec_op, w_btn_op;
  logic            r_buf_vld, r_man_seq, r_manual, r_ativa;
  logic [FW-1:0]   r_frame;
  logic [SW-1:0]   r_settle;
  logic [4:0]      r_col, w_col_n;
  logic [3:0]      r_row, w_row_n;
  logic [1:0]      r_ori;
  logic            w_adv_ok;

  logic            r_vs_s1, r_vs_s2, r_vs_d;
  logic [4:0]      r_btn_s1, r_btn_s2, r_btn_d;
  logic [4:0]      w_btn_in, w_edge;
  logic            w_tick, w_toggle, w_auto_step, w_man_step;
  logic            w_unused_btn;

  // Gamepad order here: Up, Left, Right, A, Start
  assign w_btn_in = {Entradas[6], Entradas[4], Entradas[3],
                     Entradas[2], Entradas[0]};
  assign w_unused_btn = &{1'b0, Entradas[11:7], Entradas[5], Entradas[1]};

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_vs_s1  <= 1'b1;
      r_vs_s2  <= 1'b1;
      r_vs_d   <= 1'b1;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_btn_d  <= '0;
    end else begin
      r_vs_s1  <= v_sync;
      r_vs_s2  <= r_vs_s1;
      r_vs_d   <= r_vs_s2;
      r_btn_s1 <= w_btn_in;
      r_btn_s2 <= r_btn_s1;
      r_btn_d  <= r_btn_s2;
    end
  end

  assign w_tick   = r_vs_d & ~r_vs_s2;
  assign w_edge   = r_btn_s2 & ~r_btn_d;
  assign w_toggle = w_edge[4];

  assign w_auto_step = (r_state == S_IDLE) & w_tick & ~r_manual &
                       (r_frame == FW'(FRAMES_PER_STEP - 1));
  assign w_man_step  = (r_state == S_IDLE) & w_tick & r_manual & r_buf_vld;

  always_comb begin
    w_dec_op = OP_NONE;
    if (remover)      w_dec_op = OP_REM;
    else if (girar)   w_dec_op = OP_CW;
    else if (avancar) w_dec_op = OP_ADV;
  end

  always_comb begin
    w_btn_op = OP_NONE;
    if (w_edge[3])      w_btn_op = OP_REM;
    else if (w_edge[0]) w_btn_op = OP_ADV;
    else if (w_edge[1]) w_btn_op = OP_CCW;
    else if (w_edge[2]) w_btn_op = OP_CW;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_auto_step)     w_next = S_FIRE;
        else if (w_man_step) w_next = S_APPLY;
      end
      S_FIRE:   w_next = S_SETTLE;
      S_SETTLE: begin
        if (r_settle == SW'(SETTLE_CYCLES - 1)) w_next = S_APPLY;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Advance target; the move is dropped at the maze edge rather than wrapped
  always_comb begin
    w_col_n  = r_col;
    w_row_n  = r_row;
    w_adv_ok = 1'b0;
    unique case (r_ori)
      2'd0: if (r_row != 4'd0) begin
        w_adv_ok = 1'b1;
        w_row_n  = r_row - 4'd1;
      end
      2'd1: if (r_col != 5'(GRID_COLS - 1)) begin
        w_adv_ok = 1'b1;
        w_col_n  = r_col + 5'd1;
      end
      2'd2: if (r_row != 4'(GRID_ROWS - 1)) begin
        w_adv_ok = 1'b1;
        w_row_n  = r_row + 4'd1;
      end
      2'd3: if (r_col != 5'd0) begin
        w_adv_ok = 1'b1;
        w_col_n  = r_col - 5'd1;
      end
    endcase
  end

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_ativa   <= 1'b0;
      r_frame   <= '0;
      r_settle  <= '0;
      r_op      <= OP_NONE;
      r_buf_op  <= OP_NONE;
      r_buf_vld <= 1'b0;
      r_man_seq <= 1'b0;
      r_manual  <= 1'b0;
      r_col     <= 5'(INIT_COL);
      r_row     <= 4'(INIT_ROW);
      r_ori     <= 2'd0;
    end else begin
      r_state  <= w_next;
      r_ativa  <= (w_next == S_FIRE);
      r_settle <= (r_state == S_SETTLE) ? r_settle + SW'(1) : '0;

      if (w_toggle) begin
        r_manual <= ~r_manual;
        r_frame  <= '0;
      end else if ((r_state == S_IDLE) & w_tick & ~r_manual) begin
        r_frame <= w_auto_step ? '0 : r_frame + FW'(1);
      end

      if (w_toggle) begin
        r_buf_vld <= 1'b0;
      end else if ((r_state == S_APPLY) & r_man_seq) begin
        r_buf_vld <= 1'b0;
      end else if (~r_buf_vld & (w_btn_op != OP_NONE)) begin
        r_buf_vld <= 1'b1;
        r_buf_op  <= w_btn_op;
      end

      if (w_man_step) begin
        r_op      <= r_buf_op;
        r_man_seq <= 1'b1;
      end else if (w_auto_step) begin
        r_man_seq <= 1'b0;
      end else if ((r_state == S_SETTLE) && (w_next == S_APPLY)) begin
        r_op <= w_dec_op;
      end

      if (r_state == S_APPLY) begin
        unique case (r_op)
          OP_ADV: begin
            r_col <= w_col_n;
            r_row <= w_row_n;
          end
          OP_CW:   r_ori <= r_ori + 2'd1;
          OP_CCW:  r_ori <= r_ori - 2'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef STEP_COUNTER_EN
  logic [15:0] r_steps;
  logic        w_counted;

  assign w_counted = (r_state == S_APPLY) &
                     (((r_op == OP_ADV) & w_adv_ok) | (r_op == OP_CW) |
                      (r_op == OP_CCW) | (r_op == OP_REM));

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      r_steps <= '0;
    end else if (w_counted && (r_steps != 16'hFFFF)) begin
      r_steps <= r_steps + 16'd1;
    end
  end

  assign ContadorPassos = r_steps;
`endif

  assign AtivaRobo      = r_ativa;
  assign PosColuna      = r_col;
  assign PosLinha       = r_row;
  assign OrientacaoRobo = r_ori;
  assign ModoManual     = r_manual;
  assign RemoverStrobe  = (r_state == S_APPLY) & (r_op == OP_REM);
  assign Busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_robo_step_scheduler.sv
// Bench for robo_step_scheduler: directed phases plus random decisions and
// button presses, checked against a pose/frame-count model.
module tb_robo_step_scheduler;

  localparam int F  = 2;
  localparam int S  = 4;
  localparam int GC = 20;
  localparam int GR = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs;
  logic [11:0] ent;
  logic        av, gi, rm;
  logic        ativa, man, rem_s, busy;
  logic [4:0]  col;
  logic [3:0]  row;
  logic [1:0]  ori;
`ifdef STEP_COUNTER_EN
  logic [15:0] cnt;
`endif

  always #5 clk = ~clk;

  robo_step_scheduler #(
    .GRID_COLS(GC), .GRID_ROWS(GR), .FRAMES_PER_STEP(F),
    .SETTLE_CYCLES(S), .INIT_COL(0), .INIT_ROW(0)
  ) dut (
    .Clock50(clk), .Reset(rst_n), .v_sync(vs), .Entradas(ent),
    .avancar(av), .girar(gi), .remover(rm),
    .AtivaRobo(ativa), .PosColuna(col), .PosLinha(row),
    .OrientacaoRobo(ori), .ModoManual(man), .RemoverStrobe(rem_s),
`ifdef STEP_COUNTER_EN
    .ContadorPassos(cnt),
`endif
    .Busy(busy)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int m_col, m_row, m_ori, m_fc, m_buf, m_steps;
  bit m_man;
  int dx[4] = '{0, 1, 0, -1};
  int dy[4] = '{-1, 0, 1, 0};

  task automatic chk(string tag, int obs, int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_col = 0; m_row = 0; m_ori = 0;
    m_fc = 0; m_buf = 0; m_man = 0; m_steps = 0;
  endtask

  // op: 0 none, 1 advance, 2 rotate +1, 3 rotate -1, 4 remove
  function automatic bit m_apply(int op);
    int nc, nr;
    case (op)
      1: begin
        nc = m_col + dx[m_ori];
        nr = m_row + dy[m_ori];
        if (nc < 0 || nc >= GC || nr < 0 || nr >= GR) return 0;
        m_col = nc;
        m_row = nr;
        return 1;
      end
      2: begin m_ori = (m_ori + 1) % 4; return 1; end
      3: begin m_ori = (m_ori + 3) % 4; return 1; end
      4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int pose();
    return int'({col, row, ori});
  endfunction

  task automatic run_frame(string tag);
    int op, p0, n_at, n_rm, at_at, rm_at, chg_at;
    bit step, changed;
    step = 0; op = 0; changed = 0;
    if (!m_man) begin
      m_fc++;
      if (m_fc == F) begin
        m_fc = 0;
        step = 1;
        op = rm ? 4 : gi ? 2 : av ? 1 : 0;
      end
    end else if (m_buf != 0) begin
      step = 1;
      op = m_buf;
      m_buf = 0;
    end
    if (step) changed = m_apply(op);
    if (changed && m_steps < 65535) m_steps++;

    p0 = pose();
    n_at = 0; n_rm = 0; at_at = -1; rm_at = -1; chg_at = -1;
    @(negedge clk);
    vs = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 2) vs = 1'b1;
      if (ativa) begin n_at++; if (at_at < 0) at_at = c; end
      if (rem_s) begin n_rm++; if (rm_at < 0) rm_at = c; end
      if (chg_at < 0 && pose() != p0) chg_at = c;
    end
    chk({tag, ".ativa_cycles"}, n_at, (step && !m_man) ? 1 : 0);
    chk({tag, ".rem_cycles"}, n_rm, (step && op == 4) ? 1 : 0);
    chk({tag, ".col"}, int'(col), m_col);
    chk({tag, ".row"}, int'(row), m_row);
    chk({tag, ".ori"}, int'(ori), m_ori);
    chk({tag, ".busy_end"}, int'(busy), 0);
    if (step && !m_man && op == 4)
      chk({tag, ".rem_lat"}, rm_at - at_at, 5);
    if (step && !m_man && changed && op != 4)
      chk({tag, ".pose_lat"}, chg_at - at_at, 6);
`ifdef STEP_COUNTER_EN
    chk({tag, ".steps"}, int'(cnt), m_steps);
`endif
  endtask

  task automatic press(logic [11:0] m);
    if (m[6]) begin
      m_man = !m_man;
      m_buf = 0;
      m_fc = 0;
    end else if (m_buf == 0) begin
      if (m[4])      m_buf = 4;
      else if (m[0]) m_buf = 1;
      else if (m[2]) m_buf = 3;
      else if (m[3]) m_buf = 2;
    end
    @(negedge clk);
    ent = m;
    repeat (3) @(negedge clk);
    ent = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [11:0] mk;
    int found;
    rst_n = 1'b0; vs = 1'b1; ent = '0;
    av = 1'b0; gi = 1'b0; rm = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst.col", int'(col), 0);
    chk("rst.row", int'(row), 0);
    chk("rst.ori", int'(ori), 0);
    chk("rst.manual", int'(man), 0);
    chk("rst.ativa", int'(ativa), 0);
    chk("rst.rem", int'(rem_s), 0);
    chk("rst.busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    av = 1'b1;
    for (int i = 0; i < 4; i++) run_frame("north_edge");

    av = 1'b0; gi = 1'b1;
    for (int i = 0; i < 2; i++) run_frame("turn_east");
    gi = 1'b0; av = 1'b1;
    for (int i = 0; i < 50; i++) run_frame("east_run");
    chk("east_run.hold_col", int'(col), GC - 1);

    for (int i = 0; i < 40; i++) begin
      av = ($urandom_range(0, 3) != 0);
      gi = ($urandom_range(0, 2) == 0);
      rm = ($urandom_range(0, 4) == 0);
      run_frame("rand_auto");
    end

    av = 1'b0; gi = 1'b1; rm = 1'b1;
    for (int i = 0; i < 2; i++) run_frame("rem_vs_rot");
    rm = 1'b0; gi = 1'b0; av = 1'b1;

    press(12'h040);
    chk("manual.on", int'(man), 1);
    press(12'h005);
    press(12'h008);
    run_frame("manual.up");
    run_frame("manual.empty");
    for (int i = 0; i < 20; i++) begin
      mk = '0;
      mk[0] = 1'($urandom_range(0, 1));
      mk[2] = 1'($urandom_range(0, 1));
      mk[3] = 1'($urandom_range(0, 1));
      mk[4] = ($urandom_range(0, 3) == 0);
      mk[11:7] = 5'($urandom);
      mk[1] = 1'($urandom_range(0, 1));
      press(mk);
      if ($urandom_range(0, 2) == 0) press(12'h001);
      run_frame("rand_man");
    end
    press(12'h040);
    chk("manual.off", int'(man), 0);

    av = 1'b1; gi = 1'b0; rm = 1'b0;
    if (m_fc != F - 1) run_frame("pre_reset");
    found = 0;
    @(negedge clk);
    vs = 1'b0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (c == 2) vs = 1'b1;
      if (ativa) found = 1;
    end
    vs = 1'b1;
    chk("midrst.fire_seen", found, 1);
    repeat (2) @(negedge clk);
    chk("midrst.busy_settle", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.col", int'(col), 0);
    chk("midrst.row", int'(row), 0);
    chk("midrst.ori", int'(ori), 0);
    chk("midrst.ativa", int'(ativa), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.manual", int'(man), 0);
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    av = 1'b0; gi = 1'b1;
    for (int i = 0; i < 10; i++) run_frame("rot_seq");
    chk("rot_seq.final", int'(ori), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
